// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational on lk_pc; MEM-stage resolutions train the table on the clock edge.
module branch_target_predictor #(
    parameter int unsigned ENTRIES     = 64,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned CNT_W       = 2,
    parameter bit          ALLOC_ON_NT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] lk_pc,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [31:0] lk_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        inv_all,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TGT_W  = 30;
    localparam int unsigned STAT_W = 32;
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [TGT_W-1:0]   tgt_q [ENTRIES];

    logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
    logic [STAT_W-1:0]  stat_mp_q,  stat_mp_d;

    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;
    logic               upd_hit, ent_we, alloc;
    logic [CNT_W-1:0]   cnt_cur, cnt_d;
    logic [TGT_W-1:0]   tgt_d;

    logic unused_bits;
    assign unused_bits = ^{lk_pc[1:0], lk_pc[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1],
                           upd_target[1:0]};

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];

    // Lookup sees only committed state; no bypass from a same-cycle update.
    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
        lk_target = lk_hit ? {tgt_q[lk_idx], 2'b00} : 32'h0;
    end

    always_comb begin
        cnt_cur = cnt_q[upd_idx];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ent_we  = 1'b0;
        alloc   = 1'b0;
        cnt_d   = cnt_cur;
        tgt_d   = tgt_q[upd_idx];
        if (rst_n && ce && !inv_all && upd_valid) begin
            if (upd_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    cnt_d = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_W'(1);
                    tgt_d = upd_target[31:2];
                end else begin
                    cnt_d = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_W'(1);
                end
            end else if (upd_taken || ALLOC_ON_NT) begin
                ent_we = 1'b1;
                alloc  = 1'b1;
                cnt_d  = upd_taken ? CNT_WT : CNT_WNT;
                tgt_d  = upd_target[31:2];
            end
        end
    end

    // Statistics count every accepted update, even one dropped by inv_all.
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mp_d  = stat_mp_q;
        if (ce && upd_valid) begin
            if (stat_upd_q != STAT_MAX) stat_upd_d = stat_upd_q + STAT_W'(1);
            if (upd_mispredict && (stat_mp_q != STAT_MAX)) stat_mp_d = stat_mp_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (ce) begin
            if (inv_all) valid_q <= '0;
            else if (alloc) valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ent_we) begin
            tag_q[upd_idx] <= upd_tag;
            cnt_q[upd_idx] <= cnt_d;
            tgt_q[upd_idx] <= tgt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_upd_q <= '0;
            stat_mp_q  <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mp_q  <= stat_mp_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: two BTB instances (allocate-on-not-taken off / on) against a table-of-entries model.
module tb_branch_target_predictor;
    localparam int unsigned N   = 64;
    localparam int unsigned CMX = 3;
    localparam int unsigned CWT = 2;

    logic        clk = 1'b0;
    logic        rst_n, ce, upd_valid, upd_taken, upd_mispredict, inv_all;
    logic [31:0] lk_pc, upd_pc, upd_target;
    logic        h [2];
    logic        t [2];
    logic [31:0] g [2];
    logic [31:0] su [2];
    logic [31:0] sm [2];

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .ALLOC_ON_NT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .lk_pc(lk_pc), .lk_hit(h[0]), .lk_taken(t[0]),
        .lk_target(g[0]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .inv_all(inv_all),
        .stat_updates(su[0]), .stat_mispredicts(sm[0]));

    branch_target_predictor #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .ALLOC_ON_NT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .lk_pc(lk_pc), .lk_hit(h[1]), .lk_taken(t[1]),
        .lk_target(g[1]), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .inv_all(inv_all),
        .stat_updates(su[1]), .stat_mispredicts(sm[1]));

    typedef struct {
        logic [1:0]  eh;
        logic [1:0]  et;
        logic [31:0] eg0;
        logic [31:0] eg1;
        logic [31:0] esu;
        logic [31:0] esm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: one record per BTB slot, per instance.
    bit          mv   [2][N];
    int          mtag [2][N];
    int          mcnt [2][N];
    logic [31:0] mtgt [2][N];
    logic [31:0] msu, msm;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) & 32'hFF);
    endfunction

    task automatic chk(input string name, input int a, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%h expected=%h @%0t", name, a, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) mv[a][i] = 1'b0;
            msu = 0;
            msm = 0;
        end else if (ce) begin
            if (upd_valid) begin
                if (msu != 32'hFFFF_FFFF) msu = msu + 1;
                if (upd_mispredict && msm != 32'hFFFF_FFFF) msm = msm + 1;
            end
            for (int a = 0; a < 2; a++) begin
                int i = idx_of(upd_pc);
                if (inv_all) begin
                    for (int k = 0; k < N; k++) mv[a][k] = 1'b0;
                end else if (upd_valid) begin
                    if (mv[a][i] && mtag[a][i] == tag_of(upd_pc)) begin
                        if (upd_taken) begin
                            if (mcnt[a][i] < CMX) mcnt[a][i]++;
                            mtgt[a][i] = upd_target & 32'hFFFF_FFFC;
                        end else if (mcnt[a][i] > 0) begin
                            mcnt[a][i]--;
                        end
                    end else if (upd_taken || a == 1) begin
                        mv[a][i]   = 1'b1;
                        mtag[a][i] = tag_of(upd_pc);
                        mtgt[a][i] = upd_target & 32'hFFFF_FFFC;
                        mcnt[a][i] = upd_taken ? CWT : CWT - 1;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit mp, input bit inv, input logic [31:0] lk,
                       input bit frc = 1'b0);
        exp_t e;
        @(negedge clk);
        rst_n = r; ce = c; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utg; upd_mispredict = mp; inv_all = inv; lk_pc = lk;
        if (frc) begin
            force dut0.stat_upd_q = 32'hFFFF_FFFF;
            force dut1.stat_upd_q = 32'hFFFF_FFFF;
            #1;
            release dut0.stat_upd_q;
            release dut1.stat_upd_q;
            msu = 32'hFFFF_FFFF;
        end
        for (int a = 0; a < 2; a++) begin
            int  i   = idx_of(lk);
            bit  hit = mv[a][i] && (mtag[a][i] == tag_of(lk));
            e.eh[a] = hit;
            e.et[a] = hit && (mcnt[a][i] >= CWT);
            if (a == 0) e.eg0 = hit ? mtgt[a][i] : 32'h0;
            else        e.eg1 = hit ? mtgt[a][i] : 32'h0;
        end
        e.esu = msu;
        e.esm = msm;
        sbq.push_back(e);
        model_edge();
    endtask

    task automatic look(input logic [31:0] lk);
        cyc(1, 1, 0, 32'h0, 0, 32'h0, 0, 0, lk);
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg, input logic [31:0] lk);
        cyc(1, 1, 1, pc, tk, tg, 0, 0, lk);
    endtask

    function automatic logic [31:0] rpc();
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
    endfunction

    // Monitor: the BTB presents lookup and stats every cycle; compare once inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("lk_hit",    0, 32'(h[0]), 32'(e.eh[0]));
                chk("lk_hit",    1, 32'(h[1]), 32'(e.eh[1]));
                chk("lk_taken",  0, 32'(t[0]), 32'(e.et[0]));
                chk("lk_taken",  1, 32'(t[1]), 32'(e.et[1]));
                chk("lk_target", 0, g[0], e.eg0);
                chk("lk_target", 1, g[1], e.eg1);
                for (int a = 0; a < 2; a++) begin
                    chk("stat_updates",     a, su[a], e.esu);
                    chk("stat_mispredicts", a, sm[a], e.esm);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; ce = 1; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_mispredict = 0; inv_all = 0; lk_pc = 0;
        msu = 0; msm = 0;
        for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin
            mv[a][i] = 0; mtag[a][i] = 0; mcnt[a][i] = 0; mtgt[a][i] = 0;
        end
        repeat (2) @(posedge clk);

        look(32'h0000_0100);
        upd(32'h0000_0108, 1, 32'h0000_0040, 32'h0000_0108);
        look(32'h0000_0108);
        look(32'h0001_0108);
        look(32'h0000_0508);
        repeat (3) upd(32'h0000_0108, 0, 32'h0000_0000, 32'h0000_0108);
        look(32'h0000_0108);
        repeat (2) upd(32'h0000_010B, 1, 32'h0000_0083, 32'h0000_0108);
        look(32'h0000_0108);
        upd(32'h0000_0200, 0, 32'h0000_0300, 32'h0000_0200);
        look(32'h0000_0200);
        repeat (3) cyc(1, 0, 1, 32'h0000_0108, 0, 32'h0000_0010, 1, 0, 32'h0000_0108);
        look(32'h0000_0108);

        for (int k = 0; k < 5; k++) cyc(1, 1, 1, rpc(), k[0], $urandom, k < 2, 0, 32'h0000_0108);
        cyc(1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0108);
        look(32'h0000_0108);
        look(32'h0000_0200);
        cyc(0, 1, 1, 32'h0000_0108, 1, 32'h0000_0040, 1, 0, 32'h0000_0108);
        look(32'h0000_0108);
        cyc(1, 1, 1, 32'h0000_0108, 1, 32'h0000_0040, 0, 0, 32'h0000_0108, 1'b1);
        look(32'h0000_0108);

        for (int k = 0; k < 600; k++) begin
            bit r   = ($urandom_range(0, 99) != 0);
            bit c   = ($urandom_range(0, 9) != 0);
            bit inv = ($urandom_range(0, 49) == 0);
            cyc(r, c, $urandom_range(0, 9) < 6, rpc(), $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 3) == 0, inv, rpc());
        end

        @(negedge clk);
        #4;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
